// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the ALU control sequencer: ALU operation codes, FSM states,
// instruction classes and the per-cycle control word.
package cpu_ctrl_pkg;

  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_DIV  = 5'b01111;
  localparam logic [4:0] ALU_SHR  = 5'b01001;
  localparam logic [4:0] ALU_SHRA = 5'b01010;
  localparam logic [4:0] ALU_SHL  = 5'b01011;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_NEG  = 5'b10001;
  localparam logic [4:0] ALU_NOT  = 5'b10010;
  localparam logic [4:0] ALU_INC  = 5'b11111;

  localparam logic [4:0] OP_HALT  = 5'b00000;

  typedef enum logic [3:0] {
    RST, F0, F1, F2, E3, E4, E5, E6, HLT
  } state_e;

  typedef enum logic [2:0] {
    BIN, UNARY, WIDE, HALT, ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       pc_out;
    logic       zlo_out;
    logic       zhi_out;
    logic       mdr_out;
    logic       reg_out_en;
    logic [3:0] reg_out_sel;
    logic       pc_in;
    logic       mar_in;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       reg_in_en;
    logic [3:0] reg_in_sel;
    logic       mem_read;
  } ctrl_t;

  // True for the classes that run the execute sequence through the ALU.
  function automatic logic class_is_alu(input instr_class_e c);
    return (c == BIN) || (c == UNARY) || (c == WIDE);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: maps the 5-bit opcode onto the execute
// sequence it needs. Anything not explicitly listed (including INC) is illegal.
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e op_class
);

  always_comb begin
    op_class = ILLEGAL;
    case (opcode)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SHR, ALU_SHRA, ALU_SHL, ALU_ROR, ALU_ROL: op_class = BIN;
      ALU_NEG, ALU_NOT:                             op_class = UNARY;
      ALU_MUL, ALU_DIV:                             op_class = WIDE;
      OP_HALT:                                      op_class = HALT;
      default:                                      op_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer for the ALU datapath. Define MEM_TIMEOUT_EN
// to bound the F1 memory wait by TIMEOUT_CYCLES and report bus_err on expiry.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [4:0]  alu_ctrl,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        mdr_out,
  output logic        reg_out_en,
  output logic [3:0]  reg_out_sel,
  output logic        pc_in,
  output logic        mar_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        reg_in_en,
  output logic [3:0]  reg_in_sel,
  output logic        mem_read,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instr_count,
  output state_e      state_dbg
);

  logic [4:0]   opcode;
  logic [3:0]   ra, rb, rc;
  instr_class_e op_class;
  logic         unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  alu_op_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Memory handshake: mem_read is held for every F1 cycle; the read completes
  // in the first F1 cycle where mem_ready is sampled high, and only then does
  // the sequencer leave F1.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
`ifdef MEM_TIMEOUT_EN
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
`endif
    case (state_q)
      RST: state_d = F0;
      F0: begin
        state_d = F1;
`ifdef MEM_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      F1: begin
        if (mem_ready) begin
          state_d = F2;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d   = HLT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      F2: state_d = E3;
      E3: begin
        case (op_class)
          HALT: begin
            state_d  = HLT;
            halted_d = 1'b1;
          end
          ILLEGAL: begin
            state_d   = HLT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
          default: state_d = E4;
        endcase
      end
      E4: state_d = E5;
      E5: begin
        if (op_class == WIDE) begin
          state_d = E6;
        end else begin
          state_d = F0;
          count_d = count_q + 32'd1;
        end
      end
      E6: begin
        state_d = F0;
        count_d = count_q + 32'd1;
      end
      HLT:     state_d = HLT;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= RST;
      count_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_q    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
`ifdef MEM_TIMEOUT_EN
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Control word is a function of the current state, the held IR and, in F1
  // only, mem_ready so the PC increment lands in the same cycle as the read.
  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state_q)
      F0: begin
        ctrl.pc_out   = 1'b1;
        ctrl.mar_in   = 1'b1;
        ctrl.alu_ctrl = ALU_INC;
        ctrl.z_in     = 1'b1;
      end
      F1: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.zlo_out = 1'b1;
          ctrl.pc_in   = 1'b1;
        end
      end
      F2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      E3: begin
        if (class_is_alu(op_class)) begin
          ctrl.reg_out_en  = 1'b1;
          ctrl.reg_out_sel = rb;
          ctrl.y_in        = 1'b1;
        end
      end
      E4: begin
        ctrl.reg_out_en  = 1'b1;
        ctrl.reg_out_sel = (op_class == UNARY) ? rb : rc;
        ctrl.alu_ctrl    = opcode;
        ctrl.z_in        = 1'b1;
      end
      E5: begin
        ctrl.zlo_out = 1'b1;
        if (op_class == WIDE) begin
          ctrl.lo_in = 1'b1;
        end else begin
          ctrl.reg_in_en  = 1'b1;
          ctrl.reg_in_sel = ra;
        end
      end
      E6: begin
        ctrl.zhi_out = 1'b1;
        ctrl.hi_in   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign alu_ctrl    = ctrl.alu_ctrl;
  assign pc_out      = ctrl.pc_out;
  assign zlo_out     = ctrl.zlo_out;
  assign zhi_out     = ctrl.zhi_out;
  assign mdr_out     = ctrl.mdr_out;
  assign reg_out_en  = ctrl.reg_out_en;
  assign reg_out_sel = ctrl.reg_out_sel;
  assign pc_in       = ctrl.pc_in;
  assign mar_in      = ctrl.mar_in;
  assign ir_in       = ctrl.ir_in;
  assign y_in        = ctrl.y_in;
  assign z_in        = ctrl.z_in;
  assign hi_in       = ctrl.hi_in;
  assign lo_in       = ctrl.lo_in;
  assign reg_in_en   = ctrl.reg_in_en;
  assign reg_in_sel  = ctrl.reg_in_sel;
  assign mem_read    = ctrl.mem_read;

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;
  assign state_dbg   = state_q;

`ifdef MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes the hand-derived
// control word expected for each cycle; a negedge monitor pops and compares.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int W = 62;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam int C_BIN = 0, C_UNARY = 1, C_WIDE = 2, C_HALT = 3, C_ILL = 4;

  logic        clk = 1'b0;
  logic        clear, mem_ready;
  logic [31:0] ir, ir_nxt;
  logic [4:0]  alu_ctrl;
  logic        pc_out, zlo_out, zhi_out, mdr_out, reg_out_en;
  logic [3:0]  reg_out_sel, reg_in_sel;
  logic        pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in, reg_in_en;
  logic        mem_read, halted, illegal, bus_err;
  logic [31:0] instr_count;
  state_e      dut_state;

  always #5 clk = ~clk;

  control_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .mdr_out(mdr_out), .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .pc_in(pc_in), .mar_in(mar_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
    .mem_read(mem_read), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .instr_count(instr_count), .state_dbg(dut_state)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  exp_cnt;
  logic [2:0]   flags;
  logic [W-1:0] obs;

  // src = {pc_out, zlo_out, zhi_out, mdr_out, reg_out_en}
  // ld  = {pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in}
  // fl  = {halted, illegal, bus_err}
  assign obs = {alu_ctrl, pc_out, zlo_out, zhi_out, mdr_out, reg_out_en, reg_out_sel,
                pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in, reg_in_en, reg_in_sel,
                mem_read, halted, illegal, bus_err, instr_count};

  function automatic logic [W-1:0] v(input logic [4:0] alu, input logic [4:0] src,
                                     input logic [3:0] osel, input logic [6:0] ld,
                                     input logic rin, input logic [3:0] isel,
                                     input logic mrd, input logic [2:0] fl,
                                     input logic [31:0] cnt);
    return {alu, src, osel, ld, rin, isel, mrd, fl, cnt};
  endfunction

  function automatic logic [W-1:0] idle_v(input logic [2:0] fl, input logic [31:0] cnt);
    return v(5'd0, 5'd0, 4'd0, 7'd0, 1'b0, 4'd0, 1'b0, fl, cnt);
  endfunction

  function automatic logic [W-1:0] f0_v(input logic [31:0] cnt);
    return v(5'b11111, 5'b10000, 4'd0, 7'b0100100, 1'b0, 4'd0, 1'b0, 3'b000, cnt);
  endfunction

  // Called just after a rising edge: drive this cycle's inputs, queue its expectation.
  task automatic cyc(input logic clr, input logic rdy, input logic [W-1:0] e, input string nm);
    #1;
    clear     = clr;
    mem_ready = rdy;
    ir        = ir_nxt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int waits, input int cls);
    ir_nxt = {op, ra, rb, rc, 15'd0};
    cyc(1'b0, 1'b1, f0_v(exp_cnt), "F0");
    for (int i = 0; i < waits; i++)
      cyc(1'b0, 1'b0, v(5'd0, 5'd0, 4'd0, 7'd0, 1'b0, 4'd0, 1'b1, 3'b000, exp_cnt), "F1_wait");
    cyc(1'b0, 1'b1, v(5'd0, 5'b01000, 4'd0, 7'b1000000, 1'b0, 4'd0, 1'b1, 3'b000, exp_cnt), "F1_ready");
    cyc(1'b0, 1'b1, v(5'd0, 5'b00010, 4'd0, 7'b0010000, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "F2");
    if (cls >= C_HALT) begin
      cyc(1'b0, 1'b1, idle_v(3'b000, exp_cnt), "E3_stop");
      flags = (cls == C_HALT) ? 3'b100 : 3'b110;
      cyc(1'b0, 1'b1, idle_v(flags, exp_cnt), "HLT_a");
      cyc(1'b0, 1'b1, idle_v(flags, exp_cnt), "HLT_b");
    end else begin
      cyc(1'b0, 1'b1, v(5'd0, 5'b00001, rb, 7'b0001000, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "E3");
      cyc(1'b0, 1'b1, v(op, 5'b00001, (cls == C_UNARY) ? rb : rc, 7'b0000100, 1'b0, 4'd0,
                        1'b0, 3'b000, exp_cnt), "E4");
      if (cls == C_WIDE) begin
        cyc(1'b0, 1'b1, v(5'd0, 5'b01000, 4'd0, 7'b0000001, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "E5_wide");
        cyc(1'b0, 1'b1, v(5'd0, 5'b00100, 4'd0, 7'b0000010, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "E6");
      end else begin
        cyc(1'b0, 1'b1, v(5'd0, 5'b01000, 4'd0, 7'd0, 1'b1, ra, 1'b0, 3'b000, exp_cnt), "E5");
      end
      exp_cnt = exp_cnt + 32'd1;
    end
  endtask

  // Clear while halted: the clear cycle still shows HLT, the next is RST.
  task automatic clear_from_halt();
    cyc(1'b1, 1'b1, idle_v(flags, exp_cnt), "HLT_clear");
    flags   = 3'b000;
    exp_cnt = 32'd0;
    cyc(1'b0, 1'b1, idle_v(flags, exp_cnt), "RST_after_clear");
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL %s state=%s got=%h exp=%h", nm, dut_state.name(), obs, e);
        end
      end
    end
  end

  initial begin : driver
    clear     = 1'b1;
    mem_ready = 1'b1;
    ir        = '0;
    ir_nxt    = '0;
    flags     = 3'b000;
    exp_cnt   = 32'd0;
    @(posedge clk);
    cyc(1'b1, 1'b1, idle_v(3'b000, 32'd0), "RST_hold");
    cyc(1'b0, 1'b1, idle_v(3'b000, 32'd0), "RST_exit");

    run_instr(ALU_ADD, 4'd3,  4'd1,  4'd2,  0, C_BIN);
    run_instr(ALU_MUL, 4'd7,  4'd4,  4'd5,  0, C_WIDE);
    run_instr(ALU_NEG, 4'd9,  4'd6,  4'd0,  0, C_UNARY);
    run_instr(ALU_SUB, 4'd1,  4'd2,  4'd3,  3, C_BIN);
    run_instr(ALU_DIV, 4'd12, 4'd10, 4'd11, 1, C_WIDE);
    run_instr(ALU_SHL, 4'd15, 4'd14, 4'd13, 0, C_BIN);
    run_instr(ALU_NOT, 4'd0,  4'd15, 4'd1,  0, C_UNARY);

    // Clear pulsed in E4 of an ADD: no retirement, counter back to 0.
    ir_nxt = {ALU_ADD, 4'd1, 4'd2, 4'd3, 15'd0};
    cyc(1'b0, 1'b1, f0_v(exp_cnt), "abort_F0");
    cyc(1'b0, 1'b1, v(5'd0, 5'b01000, 4'd0, 7'b1000000, 1'b0, 4'd0, 1'b1, 3'b000, exp_cnt), "abort_F1");
    cyc(1'b0, 1'b1, v(5'd0, 5'b00010, 4'd0, 7'b0010000, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "abort_F2");
    cyc(1'b0, 1'b1, v(5'd0, 5'b00001, 4'd2, 7'b0001000, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "abort_E3");
    cyc(1'b1, 1'b1, v(ALU_ADD, 5'b00001, 4'd3, 7'b0000100, 1'b0, 4'd0, 1'b0, 3'b000, exp_cnt), "abort_E4");
    exp_cnt = 32'd0;
    cyc(1'b0, 1'b1, idle_v(3'b000, exp_cnt), "abort_RST");

    run_instr(ALU_OR, 4'd2, 4'd3, 4'd4, 0, C_BIN);
    run_instr(5'b11111, 4'd1, 4'd2, 4'd3, 0, C_ILL);
    clear_from_halt();
    run_instr(5'b01100, 4'd4, 4'd5, 4'd6, 0, C_ILL);
    clear_from_halt();
    run_instr(OP_HALT, 4'd0, 4'd0, 4'd0, 0, C_HALT);
    clear_from_halt();

`ifdef MEM_TIMEOUT_EN
    ir_nxt = {ALU_ADD, 4'd1, 4'd1, 4'd1, 15'd0};
    cyc(1'b0, 1'b1, f0_v(exp_cnt), "to_F0");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, v(5'd0, 5'd0, 4'd0, 7'd0, 1'b0, 4'd0, 1'b1, 3'b000, exp_cnt), "to_F1_wait");
    flags = 3'b101;
    cyc(1'b0, 1'b0, idle_v(flags, exp_cnt), "to_HLT_a");
    cyc(1'b0, 1'b1, idle_v(flags, exp_cnt), "to_HLT_b");
    clear_from_halt();
`endif

    run_instr(ALU_ROL, 4'd8, 4'd9, 4'd10, 0, C_BIN);
    cyc(1'b0, 1'b1, f0_v(exp_cnt), "final_F0");

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
